picorv_mem_arbiter: RTL and testbench

- Two-requester arbiter in front of a single PicoRV memory port (valid/ready/insn/addr/rdata/wdata/wstrb protocol).
- Requester 0 is the core's memory interface; requester 1 is a DMA/debug master. The shared port goes to RAM or the bus.
- Exactly one transaction is outstanding at a time. It is locked from grant until the slave's ready.
- Slave-side outputs and master-side responses are registered, so no combinational path crosses the block.

---
 rtl/picorv_mem_arb_pkg.sv | 14 +
 rtl/picorv_rr_pick2.sv | 22 ++
 rtl/picorv_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_picorv_mem_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv_mem_arb_pkg.sv
// Shared constants for the PicoRV two-requester memory arbiter.
package picorv_mem_arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

  // Every bit of the read data returned on a timed-out transaction takes this value.
  localparam logic TIMEOUT_RDATA_FILL = 1'b1;

endpackage

// File: rtl/picorv_rr_pick2.sv
// Combinational 2-way picker: a sole requester wins, contention is settled by last/round_robin.
module picorv_rr_pick2
  import picorv_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       round_robin,
  output logic       any,
  output logic       winner
);

  always_comb begin
    any    = |req;
    winner = GNT_M0;
    if (req == 2'b10) begin
      winner = GNT_M1;
    end else if (req == 2'b11) begin
      winner = round_robin ? ~last : GNT_M0;
    end
  end

endmodule

// File: rtl/picorv_mem_arbiter.sv
// Two-requester arbiter in front of one PicoRV memory port, one locked transaction at a time.
// Optional slave response timeout is enabled with `define PICORV_MEM_ARB_TIMEOUT_EN.
module picorv_mem_arbiter
  import picorv_mem_arb_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT     = 256
) (
  input  logic            clock,
  input  logic            resetn,

  input  logic            m0_valid,
  output logic            m0_ready,
  input  logic            m0_insn,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  input  logic [3:0]      m0_wstrb,
  output logic [XLEN-1:0] m0_rdata,

  input  logic            m1_valid,
  output logic            m1_ready,
  input  logic            m1_insn,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic [3:0]      m1_wstrb,
  output logic [XLEN-1:0] m1_rdata,

  output logic            s_valid,
  input  logic            s_ready,
  output logic            s_insn,
  output logic [XLEN-1:0] s_addr,
  output logic [XLEN-1:0] s_wdata,
  output logic [3:0]      s_wstrb,
  input  logic [XLEN-1:0] s_rdata,

  output logic            timeout_err
);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("picorv_mem_arbiter: TIMEOUT must be >= 2");
  end

  logic [1:0]      state;
  logic            gnt;
  logic            last;
  logic            pick_any;
  logic            pick_winner;
  logic            tmo_hit;
  logic            done;
  logic [XLEN-1:0] resp_data;

  logic            req_insn;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [3:0]      req_wstrb;

  picorv_rr_pick2 u_pick (
    .req         ({m1_valid, m0_valid}),
    .last        (last),
    .round_robin (ROUND_ROBIN != 0),
    .any         (pick_any),
    .winner      (pick_winner)
  );

  always_comb begin
    req_insn  = m0_insn;
    req_addr  = m0_addr;
    req_wdata = m0_wdata;
    req_wstrb = m0_wstrb;
    if (pick_winner == GNT_M1) begin
      req_insn  = m1_insn;
      req_addr  = m1_addr;
      req_wdata = m1_wdata;
      req_wstrb = m1_wstrb;
    end
  end

`ifdef PICORV_MEM_ARB_TIMEOUT_EN
  localparam int unsigned   CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Held at zero outside BUSY, which is the same as clearing it on entry.
  always_ff @(posedge clock) begin
    if (!resetn || state != ST_BUSY) begin
      tmo_cnt <= '0;
    end else if (!s_ready) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state == ST_BUSY) && !s_ready && (tmo_cnt == CNT_LAST);
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // A timeout never fires in the same cycle as s_ready, so a late response still wins.
  assign done      = (state == ST_BUSY) && (s_ready || tmo_hit);
  assign resp_data = tmo_hit ? {XLEN{TIMEOUT_RDATA_FILL}} : s_rdata;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      gnt      <= GNT_M0;
      last     <= GNT_M1;
      s_valid  <= 1'b0;
      s_insn   <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
`ifdef PICORV_MEM_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
`ifdef PICORV_MEM_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            s_valid <= 1'b1;
            s_insn  <= req_insn;
            s_addr  <= req_addr;
            s_wdata <= req_wdata;
            s_wstrb <= req_wstrb;
            gnt     <= pick_winner;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done) begin
            s_valid <= 1'b0;
            last    <= gnt;
            state   <= ST_RESP;
            if (gnt == GNT_M1) begin
              m1_ready <= 1'b1;
              m1_rdata <= resp_data;
            end else begin
              m0_ready <= 1'b1;
              m0_rdata <= resp_data;
            end
`ifdef PICORV_MEM_ARB_TIMEOUT_EN
            timeout_err <= tmo_hit;
`endif
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv_mem_arbiter.sv
// Self-checking bench for picorv_mem_arbiter: directed scenarios plus a randomized run against a transaction model.
module tb_picorv_mem_arbiter;

  localparam int unsigned XLEN = 32;
`ifdef PICORV_MEM_ARB_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 8;
`else
  localparam int unsigned TB_TIMEOUT = 256;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            resetn;
  logic            m0_valid, m0_insn, m1_valid, m1_insn;
  logic [XLEN-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]      m0_wstrb, m1_wstrb;
  logic            s_ready;
  logic [XLEN-1:0] s_rdata;

  logic            m0_ready, m1_ready, s_valid, s_insn, timeout_err;
  logic [XLEN-1:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]      s_wstrb;

  logic            fp_m0_ready, fp_m1_ready, fp_s_valid, fp_s_insn, fp_timeout_err;
  logic [XLEN-1:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic [3:0]      fp_s_wstrb;

  int checks = 0;
  int errors = 0;

  picorv_mem_arbiter #(.ROUND_ROBIN(1), .XLEN(XLEN), .TIMEOUT(TB_TIMEOUT)) dut (
    .clock(clock), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_insn(m0_insn), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_insn(m1_insn), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_insn(s_insn), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata), .timeout_err(timeout_err)
  );

  picorv_mem_arbiter #(.ROUND_ROBIN(0), .XLEN(XLEN), .TIMEOUT(TB_TIMEOUT)) dut_fp (
    .clock(clock), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(fp_m0_ready), .m0_insn(m0_insn), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(fp_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(fp_m1_ready), .m1_insn(m1_insn), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(fp_m1_rdata),
    .s_valid(fp_s_valid), .s_ready(s_ready), .s_insn(fp_s_insn), .s_addr(fp_s_addr),
    .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb), .s_rdata(s_rdata), .timeout_err(fp_timeout_err)
  );

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic idle_inputs;
    m0_valid = 1'b0; m0_insn = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_insn = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset;
    resetn = 1'b0;
    idle_inputs();
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    resetn   = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h1234; m0_wstrb = 4'hf; m0_wdata = 32'h5555_aaaa; m0_insn = 1'b1;
    m1_valid = 1'b1; m1_addr = 32'h5678;
    s_ready  = 1'b1; s_rdata = 32'hffff_0000;
    tick();
    tick();
    checks++;
    if ({s_valid, s_insn, s_wstrb} !== 6'b0) begin
      errors++; $display("FAIL reset_s_ctrl got %b want 000000", {s_valid, s_insn, s_wstrb});
    end
    checks++;
    if ({s_addr, s_wdata} !== 64'h0) begin
      errors++; $display("FAIL reset_s_data got %h want 0", {s_addr, s_wdata});
    end
    checks++;
    if ({m0_ready, m1_ready, timeout_err} !== 3'b000) begin
      errors++; $display("FAIL reset_ready got %b want 000", {m0_ready, m1_ready, timeout_err});
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata got %h want 0", {m0_rdata, m1_rdata});
    end
    checks++;
    if ({fp_s_valid, fp_m0_ready, fp_m1_ready, fp_s_addr} !== 35'h0) begin
      errors++; $display("FAIL reset_fp got %h want 0", {fp_s_valid, fp_m0_ready, fp_m1_ready, fp_s_addr});
    end
    resetn = 1'b1;
    idle_inputs();
  endtask

  task automatic test_single_read;
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0; m0_insn = 1'b0; m0_wdata = $urandom;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (s_valid !== (c >= 1 && c <= 3)) begin
        errors++; $display("FAIL single_svalid cycle %0d got %b want %b", c, s_valid, (c >= 1 && c <= 3));
      end
      if (c <= 3) begin
        checks++;
        if ({s_addr, s_wstrb} !== {32'h100, 4'h0}) begin
          errors++; $display("FAIL single_saddr cycle %0d got %h/%h want 100/0", c, s_addr, s_wstrb);
        end
      end
      checks++;
      if ({m0_ready, m1_ready} !== {(c == 4), 1'b0}) begin
        errors++; $display("FAIL single_ready cycle %0d got %b want %b", c, {m0_ready, m1_ready}, {(c == 4), 1'b0});
      end
      if (c >= 4) begin
        checks++;
        if (m0_rdata !== 32'hDEADBEEF) begin
          errors++; $display("FAIL single_rdata cycle %0d got %h want deadbeef", c, m0_rdata);
        end
      end
      if (c == 4) m0_valid = 1'b0;
      s_ready = (c == 3);
      s_rdata = (c == 3) ? 32'hDEADBEEF : $urandom;
    end
    idle_inputs();
  endtask

  task automatic test_contention_rr;
    logic [XLEN-1:0] want_addr;
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h10;
    m1_valid = 1'b1; m1_addr = 32'h20;
    s_ready  = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      s_rdata = $urandom;
      tick();
      checks++;
      if (s_valid !== (c % 3 == 1)) begin
        errors++; $display("FAIL rr_svalid cycle %0d got %b want %b", c, s_valid, (c % 3 == 1));
      end
      if (c % 3 == 1) begin
        want_addr = ((c / 3) % 2 == 0) ? 32'h10 : 32'h20;
        checks++;
        if (s_addr !== want_addr) begin
          errors++; $display("FAIL rr_saddr cycle %0d got %h want %h", c, s_addr, want_addr);
        end
      end
      checks++;
      if ({m0_ready, m1_ready} !== {(c == 2 || c == 8), (c == 5 || c == 11)}) begin
        errors++; $display("FAIL rr_ready cycle %0d got %b want %b", c, {m0_ready, m1_ready},
                           {(c == 2 || c == 8), (c == 5 || c == 11)});
      end
    end
    idle_inputs();
  endtask

  task automatic test_fixed_priority;
    logic [XLEN-1:0] want_addr;
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h10;
    m1_valid = 1'b1; m1_addr = 32'h20;
    s_ready  = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if (fp_s_valid !== (c == 1 || c == 4 || c == 7 || c == 10)) begin
        errors++; $display("FAIL fp_svalid cycle %0d got %b want %b", c, fp_s_valid, (c == 1 || c == 4 || c == 7 || c == 10));
      end
      if (fp_s_valid) begin
        want_addr = (c < 10) ? 32'h10 : 32'h20;
        checks++;
        if (fp_s_addr !== want_addr) begin
          errors++; $display("FAIL fp_saddr cycle %0d got %h want %h", c, fp_s_addr, want_addr);
        end
      end
      checks++;
      if ({fp_m0_ready, fp_m1_ready} !== {(c == 2 || c == 5 || c == 8), (c == 11)}) begin
        errors++; $display("FAIL fp_ready cycle %0d got %b want %b", c, {fp_m0_ready, fp_m1_ready},
                           {(c == 2 || c == 5 || c == 8), (c == 11)});
      end
      if (c == 8) m0_valid = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_write;
    int lat;
    int pulses;
    do_reset();
    lat    = $urandom_range(1, 4);
    pulses = 0;
    m1_valid = 1'b1; m1_addr = 32'h44; m1_wdata = 32'h0000ABCD; m1_wstrb = 4'b0011; m1_insn = 1'b0;
    for (int c = 1; c <= lat + 4; c++) begin
      tick();
      checks++;
      if (s_valid !== (c <= lat)) begin
        errors++; $display("FAIL write_svalid cycle %0d got %b want %b", c, s_valid, (c <= lat));
      end
      if (c <= lat) begin
        checks++;
        if ({s_insn, s_addr, s_wdata, s_wstrb} !== {1'b0, 32'h44, 32'h0000ABCD, 4'b0011}) begin
          errors++; $display("FAIL write_fields cycle %0d got %b/%h/%h/%b want 0/44/0000abcd/0011",
                             c, s_insn, s_addr, s_wdata, s_wstrb);
        end
      end
      checks++;
      if ({m0_ready, m1_ready} !== {1'b0, (c == lat + 1)}) begin
        errors++; $display("FAIL write_ready cycle %0d got %b want %b", c, {m0_ready, m1_ready}, {1'b0, (c == lat + 1)});
      end
      if (m1_ready) begin
        pulses++;
        m1_valid = 1'b0;
      end
      s_ready = (c == lat);
      s_rdata = $urandom;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL write_pulses got %0d want 1", pulses);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_busy;
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h300; m0_wstrb = 4'h0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      checks++;
      if (s_valid !== (c <= 2 || c == 7)) begin
        errors++; $display("FAIL rstbusy_svalid cycle %0d got %b want %b", c, s_valid, (c <= 2 || c == 7));
      end
      checks++;
      if ({m0_ready, m1_ready} !== 2'b00) begin
        errors++; $display("FAIL rstbusy_ready cycle %0d got %b want 00", c, {m0_ready, m1_ready});
      end
      if (c == 7) begin
        checks++;
        if (s_addr !== 32'h80) begin
          errors++; $display("FAIL rstbusy_idle_grant got %h want 80", s_addr);
        end
      end
      case (c)
        2: resetn = 1'b0;
        3: begin resetn = 1'b1; m0_valid = 1'b0; s_ready = 1'b1; s_rdata = 32'h0bad_0bad; end
        6: begin s_ready = 1'b0; m1_valid = 1'b1; m1_addr = 32'h80; end
        default: ;
      endcase
    end
    idle_inputs();
  endtask

  task automatic test_timeout;
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h200; m0_wstrb = 4'h0;
`ifdef PICORV_MEM_ARB_TIMEOUT_EN
    for (int c = 1; c <= 11; c++) begin
      tick();
      checks++;
      if (s_valid !== (c <= 8)) begin
        errors++; $display("FAIL tmo_svalid cycle %0d got %b want %b", c, s_valid, (c <= 8));
      end
      checks++;
      if ({m0_ready, timeout_err} !== {(c == 9), (c == 9)}) begin
        errors++; $display("FAIL tmo_pulse cycle %0d got %b want %b", c, {m0_ready, timeout_err}, {(c == 9), (c == 9)});
      end
      if (c == 9) begin
        checks++;
        if (m0_rdata !== 32'hFFFFFFFF) begin
          errors++; $display("FAIL tmo_rdata got %h want ffffffff", m0_rdata);
        end
        m0_valid = 1'b0;
      end
    end
`else
    for (int c = 1; c <= 40; c++) begin
      tick();
      checks++;
      if ({s_valid, m0_ready, timeout_err} !== 3'b100) begin
        errors++; $display("FAIL notmo_wait cycle %0d got %b want 100", c, {s_valid, m0_ready, timeout_err});
      end
    end
`endif
    idle_inputs();
  endtask

  // Randomized traffic against a transaction-level timeline model.
  task automatic test_random;
    logic            req_on  [2];
    logic            req_insn[2];
    logic [XLEN-1:0] req_addr[2];
    logic [XLEN-1:0] req_wdata[2];
    logic [3:0]      req_wstrb[2];
    logic [XLEN-1:0] exp_rdata[2];
    logic [1:0]      exp_ready;
    logic            exp_svalid;
    logic [68:0]     exp_sfields;
    int              owner;
    int              winner;
    int              prev;
    int              waited;
    logic            gap;
    logic            sr;
    logic [XLEN-1:0] sd;

    do_reset();
    for (int k = 0; k < 2; k++) begin
      req_on[k] = 1'b0; req_insn[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0; req_wstrb[k] = '0;
      exp_rdata[k] = '0;
    end
    exp_ready = 2'b00; exp_svalid = 1'b0; exp_sfields = '0;
    owner = -1; prev = 1; waited = 0; gap = 1'b0;

    for (int n = 0; n < 600; n++) begin
      checks++;
      if (s_valid !== exp_svalid) begin
        errors++; $display("FAIL rand_svalid cycle %0d got %b want %b", n, s_valid, exp_svalid);
      end
      if (exp_svalid) begin
        checks++;
        if ({s_insn, s_addr, s_wdata, s_wstrb} !== exp_sfields) begin
          errors++; $display("FAIL rand_sfields cycle %0d got %h want %h", n, {s_insn, s_addr, s_wdata, s_wstrb}, exp_sfields);
        end
      end
      checks++;
      if ({m1_ready, m0_ready} !== exp_ready) begin
        errors++; $display("FAIL rand_ready cycle %0d got %b want %b", n, {m1_ready, m0_ready}, exp_ready);
      end
      checks++;
      if ({m0_rdata, m1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
        errors++; $display("FAIL rand_rdata cycle %0d got %h/%h want %h/%h", n, m0_rdata, m1_rdata, exp_rdata[0], exp_rdata[1]);
      end

      // Requesters: a served request retires on its ready; the owner occasionally drops valid early.
      for (int k = 0; k < 2; k++) begin
        if (exp_ready[k]) req_on[k] = 1'b0;
        if (owner == k && $urandom_range(0, 15) == 0) req_on[k] = 1'b0;
        if (!req_on[k] && owner != k && $urandom_range(0, 2) == 0) begin
          req_on[k]    = 1'b1;
          req_insn[k]  = 1'($urandom);
          req_addr[k]  = $urandom;
          req_wdata[k] = $urandom;
          req_wstrb[k] = 4'($urandom);
        end
      end
      sr = ($urandom_range(0, 2) == 0) || (owner >= 0 && waited >= 4);
      sd = $urandom;

      m0_valid = req_on[0]; m0_insn = req_insn[0]; m0_addr = req_addr[0]; m0_wdata = req_wdata[0]; m0_wstrb = req_wstrb[0];
      m1_valid = req_on[1]; m1_insn = req_insn[1]; m1_addr = req_addr[1]; m1_wdata = req_wdata[1]; m1_wstrb = req_wstrb[1];
      s_ready  = sr;
      s_rdata  = sd;

      // Timeline: grant -> wait for slave -> one response cycle -> one dead cycle -> next grant.
      exp_ready = 2'b00;
      if (owner >= 0) begin
        if (sr) begin
          exp_ready[owner] = 1'b1;
          exp_rdata[owner] = sd;
          exp_svalid = 1'b0;
          prev  = owner;
          owner = -1;
          gap   = 1'b1;
        end else begin
          waited++;
        end
      end else if (gap) begin
        gap = 1'b0;
      end else if (req_on[0] || req_on[1]) begin
        if (req_on[0] && req_on[1]) winner = 1 - prev;
        else winner = req_on[1] ? 1 : 0;
        owner       = winner;
        waited      = 0;
        exp_svalid  = 1'b1;
        exp_sfields = {req_insn[winner], req_addr[winner], req_wdata[winner], req_wstrb[winner]};
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    test_reset();
    test_single_read();
    test_contention_rr();
    test_fixed_priority();
    test_write();
    test_reset_mid_busy();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
